// File: rtl/serial_parity_pkg.sv
// Shared definitions for the 4-bit even-parity serial link (rx and tx sides).
package serial_parity_pkg;

    localparam int unsigned FRAME_DATA_BITS = 4;
    localparam logic        PARITY_EVEN     = 1'b0;

    // Position of each bit within a frame, in transmission order.
    localparam int unsigned BIT_START  = 0;
    localparam int unsigned BIT_D0     = 1;
    localparam int unsigned BIT_D3     = 4;
    localparam int unsigned BIT_PARITY = 5;
    localparam int unsigned BIT_STOP   = 6;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to 1 so an idle serial line reads as idle.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Receiver for 4-bit even-parity frames: start, d0..d3 (LSB first), p, stop.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RX_IDLE   | line idle, waiting for sin_s low
// RX_START  | half a bit into the start bit; high at sample = glitch
// RX_DATA   | sampling d0..d3 at mid-bit into the shift register
// RX_PARITY | sampling the parity bit
// RX_STOP   | sampling the stop bit, then publishing the word next edge
// RX_BREAK  | stop bit was 0; wait for the line to return high
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    output logic [3:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned DW   = $clog2(FRAME_DATA_BITS);

    logic                       sin_s;
    rx_state_t                  state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [2:0]                 fbit_q, fbit_d;
    logic [FRAME_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                       par_q, par_d;
    logic                       stop_q, stop_d;
    logic                       pend_q, pend_d;
    logic [3:0]                 data_q, data_d;
    logic                       dv_q, dv_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;
    logic                       half_hit;
    logic                       bit_hit;
    logic [DW-1:0]              didx;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sin),
        .q_o   (sin_s)
    );

    assign half_hit = (cnt_q == CW'(HALF - 1));
    assign bit_hit  = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign didx     = DW'(fbit_q - 3'(BIT_D0));

    // Register all FSM, datapath and output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            fbit_q  <= 3'(BIT_START);
            shreg_q <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b1;
            pend_q  <= 1'b0;
            data_q  <= 4'b0000;
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fbit_q  <= fbit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state, mid-bit sampling and frame-end output update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fbit_d  = fbit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        stop_d  = stop_q;
        pend_d  = pend_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        case (state_q)
            RX_IDLE: begin
                cnt_d  = '0;
                fbit_d = 3'(BIT_START);
                pend_d = 1'b0;
                if (!sin_s) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (half_hit) begin
                    cnt_d = '0;
                    if (sin_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        fbit_d  = 3'(BIT_D0);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (bit_hit) begin
                    cnt_d         = '0;
                    shreg_d[didx] = sin_s;
                    if (fbit_q == 3'(BIT_D3)) begin
                        state_d = RX_PARITY;
                        fbit_d  = 3'(BIT_PARITY);
                    end else begin
                        fbit_d = fbit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_PARITY: begin
                if (bit_hit) begin
                    cnt_d   = '0;
                    par_d   = sin_s;
                    state_d = RX_STOP;
                    fbit_d  = 3'(BIT_STOP);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                // Stop is sampled first; the word is published one edge later.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    data_d  = shreg_q;
                    perr_d  = ((^shreg_q) ^ par_q) != PARITY_EVEN;
                    ferr_d  = ~stop_q;
                    dv_d    = 1'b1;
                    state_d = stop_q ? RX_IDLE : RX_BREAK;
                end else if (bit_hit) begin
                    cnt_d  = '0;
                    stop_d = sin_s;
                    pend_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_BREAK: begin
                cnt_d = '0;
                if (sin_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx with CLKS_PER_BIT = 4.
module tb_serial_parity_rx;

    logic       clk;
    logic       rst_n;
    logic       sin;
    logic [3:0] data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         pulse_cnt = 0;
    int         busy_cycles = 0;
    int         pulse_cyc  [16];
    logic [3:0] pulse_data [16];
    logic       pulse_perr [16];
    logic       pulse_ferr [16];

    serial_parity_rx #(.CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .data       (data),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every data_valid pulse with its cycle and qualifiers.
    always @(negedge clk) begin
        if (busy) busy_cycles = busy_cycles + 1;
        if (data_valid) begin
            if (pulse_cnt < 16) begin
                pulse_cyc[pulse_cnt]  = cyc;
                pulse_data[pulse_cnt] = data;
                pulse_perr[pulse_cnt] = parity_err;
                pulse_ferr[pulse_cnt] = frame_err;
            end
            pulse_cnt = pulse_cnt + 1;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_bit(input logic b);
        sin = b;
        repeat (4) @(negedge clk);
    endtask

    // Called at a negedge; returns T0 (posedge number that first sees sin low).
    task automatic send_frame(input logic [3:0] d, input logic p, input logic stp, output int t0);
        t0 = cyc + 1;
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(d[i]);
        hold_bit(p);
        hold_bit(stp);
    endtask

    int t0a, t0b, base, bsnap;

    initial begin
        sin   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_data", {28'd0, data}, 32'h0);
        chk_eq("rst_dv",   {31'd0, data_valid}, 32'h0);
        chk_eq("rst_perr", {31'd0, parity_err}, 32'h0);
        chk_eq("rst_ferr", {31'd0, frame_err}, 32'h0);
        chk_eq("rst_busy", {31'd0, busy}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean frame 1011, p=1.
        base = pulse_cnt;
        send_frame(4'b1011, 1'b1, 1'b1, t0a);
        repeat (6) @(negedge clk);
        chk_eq("clean_npulse", pulse_cnt - base, 1);
        chk_eq("clean_time",   pulse_cyc[base], t0a + 29);
        chk_eq("clean_data",   {28'd0, pulse_data[base]}, 32'hb);
        chk_eq("clean_perr",   {31'd0, pulse_perr[base]}, 0);
        chk_eq("clean_ferr",   {31'd0, pulse_ferr[base]}, 0);
        chk_eq("clean_busy",   {31'd0, busy}, 0);

        // Same word, wrong parity.
        base = pulse_cnt;
        send_frame(4'b1011, 1'b0, 1'b1, t0a);
        repeat (6) @(negedge clk);
        chk_eq("par_npulse", pulse_cnt - base, 1);
        chk_eq("par_data",   {28'd0, data}, 32'hb);
        chk_eq("par_perr",   {31'd0, parity_err}, 1);
        chk_eq("par_ferr",   {31'd0, frame_err}, 0);

        // Stop bit 0, line held low: break.
        base = pulse_cnt;
        send_frame(4'b0000, 1'b0, 1'b0, t0a);
        repeat (20) @(negedge clk);
        chk_eq("brk_npulse", pulse_cnt - base, 1);
        chk_eq("brk_ferr",   {31'd0, frame_err}, 1);
        chk_eq("brk_perr",   {31'd0, parity_err}, 0);
        chk_eq("brk_data",   {28'd0, data}, 32'h0);
        chk_eq("brk_busy",   {31'd0, busy}, 1);
        sin = 1'b1;
        repeat (8) @(negedge clk);
        chk_eq("brk_exit_busy", {31'd0, busy}, 0);
        chk_eq("brk_exit_npulse", pulse_cnt - base, 1);
        base = pulse_cnt;
        send_frame(4'b0101, 1'b0, 1'b1, t0a);
        repeat (6) @(negedge clk);
        chk_eq("post_brk_npulse", pulse_cnt - base, 1);
        chk_eq("post_brk_time",   pulse_cyc[base], t0a + 29);
        chk_eq("post_brk_data",   {28'd0, data}, 32'h5);
        chk_eq("post_brk_perr",   {31'd0, parity_err}, 0);
        chk_eq("post_brk_ferr",   {31'd0, frame_err}, 0);

        // One-cycle glitch on an idle line.
        base  = pulse_cnt;
        bsnap = busy_cycles;
        sin = 1'b0;
        @(negedge clk);
        sin = 1'b1;
        repeat (12) @(negedge clk);
        chk_eq("glitch_busy_seen", (busy_cycles - bsnap) > 0 ? 1 : 0, 1);
        chk_eq("glitch_npulse", pulse_cnt - base, 0);
        chk_eq("glitch_busy",   {31'd0, busy}, 0);
        chk_eq("glitch_data",   {28'd0, data}, 32'h5);
        chk_eq("glitch_perr",   {31'd0, parity_err}, 0);
        chk_eq("glitch_ferr",   {31'd0, frame_err}, 0);

        // Reset in the middle of d2.
        base = pulse_cnt;
        hold_bit(1'b0);
        hold_bit(1'b0);
        hold_bit(1'b1);
        sin = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("mid_busy", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("arst_data", {28'd0, data}, 32'h0);
        chk_eq("arst_busy", {31'd0, busy}, 0);
        chk_eq("arst_dv",   {31'd0, data_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sin = 1'b1;
        repeat (30) @(negedge clk);
        chk_eq("arst_npulse", pulse_cnt - base, 0);
        base = pulse_cnt;
        send_frame(4'b1110, 1'b1, 1'b1, t0a);
        repeat (6) @(negedge clk);
        chk_eq("after_rst_npulse", pulse_cnt - base, 1);
        chk_eq("after_rst_data",   {28'd0, data}, 32'he);
        chk_eq("after_rst_perr",   {31'd0, parity_err}, 0);
        chk_eq("after_rst_ferr",   {31'd0, frame_err}, 0);

        // Back-to-back frames.
        base = pulse_cnt;
        send_frame(4'b0001, 1'b1, 1'b1, t0a);
        send_frame(4'b1000, 1'b1, 1'b1, t0b);
        repeat (6) @(negedge clk);
        chk_eq("b2b_npulse", pulse_cnt - base, 2);
        chk_eq("b2b_t1",     pulse_cyc[base], t0a + 29);
        chk_eq("b2b_gap",    pulse_cyc[base + 1] - pulse_cyc[base], 28);
        chk_eq("b2b_d1",     {28'd0, pulse_data[base]}, 32'h1);
        chk_eq("b2b_d2",     {28'd0, pulse_data[base + 1]}, 32'h8);
        chk_eq("b2b_err1",   {30'd0, pulse_perr[base], pulse_ferr[base]}, 0);
        chk_eq("b2b_err2",   {30'd0, pulse_perr[base + 1], pulse_ferr[base + 1]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
